// File: rtl/phy_rx_sync_ctrl_if.sv
// Purpose: bundle of the receive-controller link signals between the
//          serial PHY front end (master) and phy_rx_sync_ctrl (slave).
// Signals:
//   rx_en    link enable, low forces the controller back to hunting
//   data_in  serial data, MSB first, one bit per clk_32f
//   byte_out last forwarded data byte
//   byte_stb one-cycle pulse marking a new byte_out/lane_sel
//   lane_sel demux lane (0..3) of byte_out
//   active   link locked
//   idl      idle indication returned to the TX side
//   state    controller state (00 SEARCH, 01 ALIGN, 10 ACTIVE)
interface phy_rx_sync_ctrl_if;
    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned LANE_W  = 2;
    localparam int unsigned STATE_W = 2;

    logic                 rx_en;
    logic                 data_in;
    logic [BYTE_W-1:0]    byte_out;
    logic                 byte_stb;
    logic [LANE_W-1:0]    lane_sel;
    logic                 active;
    logic                 idl;
    logic [STATE_W-1:0]   state;

    modport master (
        output rx_en, data_in,
        input  byte_out, byte_stb, lane_sel, active, idl, state
    );

    modport slave (
        input  rx_en, data_in,
        output byte_out, byte_stb, lane_sel, active, idl, state
    );
endinterface

// File: rtl/phy_rx_sync_ctrl.sv
// Purpose: receive-side serial link controller in the 32f domain. Hunts for
//          COMMA symbols to find byte alignment, locks after LOCK_COUNT
//          consecutive aligned COMMAs, then forwards data bytes with a
//          round-robin lane index for the 1-to-4 demux and drives the IDLE
//          indication back to the TX side.
// Ports:
//   clk_32f  bit clock, rising edge
//   rst      synchronous active-high reset
//   bus      phy_rx_sync_ctrl_if.slave (rx_en, data_in in; byte_out,
//            byte_stb, lane_sel, active, idl, state out)
module phy_rx_sync_ctrl #(
    parameter logic [7:0]  COMMA      = 8'hBC,
    parameter logic [7:0]  IDLE_SYM   = 8'h7C,
    parameter int unsigned LOCK_COUNT = 4
) (
    input  logic                clk_32f,
    input  logic                rst,
    phy_rx_sync_ctrl_if.slave   bus
);
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned SR_W   = BYTE_W - 1;
    localparam int unsigned BIT_W  = 3;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned LANE_W = 2;

    typedef enum logic [1:0] {
        S_SEARCH = 2'b00,
        S_ALIGN  = 2'b01,
        S_ACTIVE = 2'b10
    } state_e;

    // Only the 7 newest bits are ever read back, so the oldest shift stage
    // is not kept.
    logic [SR_W-1:0]   sr_q,       sr_d;
    logic [BIT_W-1:0]  bit_cnt_q,  bit_cnt_d;
    logic [CNT_W-1:0]  bc_cnt_q,   bc_cnt_d;
    logic [LANE_W-1:0] ptr_q,      ptr_d;
    logic [LANE_W-1:0] lane_q,     lane_d;
    logic [BYTE_W-1:0] byte_out_q, byte_out_d;
    logic              byte_stb_q, byte_stb_d;
    logic              active_q,   active_d;
    logic              idl_q,      idl_d;
    state_e            state_q,    state_d;

    logic [BYTE_W-1:0] nsr_c;
    logic              boundary_c;
    logic [CNT_W-1:0]  bc_inc_c;

    // State and datapath registers
    always_ff @(posedge clk_32f) begin
        if (rst) begin
            sr_q       <= '0;
            bit_cnt_q  <= '0;
            bc_cnt_q   <= '0;
            ptr_q      <= '0;
            lane_q     <= '0;
            byte_out_q <= '0;
            byte_stb_q <= 1'b0;
            active_q   <= 1'b0;
            idl_q      <= 1'b1;
            state_q    <= S_SEARCH;
        end else begin
            sr_q       <= sr_d;
            bit_cnt_q  <= bit_cnt_d;
            bc_cnt_q   <= bc_cnt_d;
            ptr_q      <= ptr_d;
            lane_q     <= lane_d;
            byte_out_q <= byte_out_d;
            byte_stb_q <= byte_stb_d;
            active_q   <= active_d;
            idl_q      <= idl_d;
            state_q    <= state_d;
        end
    end

    // Next-state and output decode
    always_comb begin
        nsr_c      = {sr_q, bus.data_in};
        boundary_c = (bit_cnt_q == BIT_W'(7));
        bc_inc_c   = bc_cnt_q + CNT_W'(1);

        sr_d       = nsr_c[SR_W-1:0];
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        bc_cnt_d   = bc_cnt_q;
        ptr_d      = ptr_q;
        lane_d     = lane_q;
        byte_out_d = byte_out_q;
        byte_stb_d = 1'b0;
        idl_d      = idl_q;

        if (!bus.rx_en) begin
            state_d   = S_SEARCH;
            bit_cnt_d = '0;
            bc_cnt_d  = '0;
            ptr_d     = '0;
            lane_d    = '0;
            idl_d     = 1'b1;
        end else begin
            case (state_q)
                S_SEARCH: begin
                    // Bit-by-bit hunt; a hit defines the byte phase.
                    bit_cnt_d = '0;
                    idl_d     = 1'b1;
                    if (nsr_c == COMMA) begin
                        bc_cnt_d = CNT_W'(1);
                        if (LOCK_COUNT == 1) begin
                            state_d = S_ACTIVE;
                            ptr_d   = '0;
                            lane_d  = '0;
                        end else begin
                            state_d = S_ALIGN;
                        end
                    end
                end
                S_ALIGN: begin
                    bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    idl_d     = 1'b1;
                    if (boundary_c) begin
                        if (nsr_c == COMMA) begin
                            bc_cnt_d = bc_inc_c;
                            if (bc_inc_c == CNT_W'(LOCK_COUNT)) begin
                                state_d = S_ACTIVE;
                                ptr_d   = '0;
                                lane_d  = '0;
                            end
                        end else begin
                            bc_cnt_d = '0;
                            state_d  = S_SEARCH;
                        end
                    end
                end
                S_ACTIVE: begin
                    bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    if (boundary_c) begin
                        if (nsr_c == COMMA) begin
                            // Frame restart: next data byte goes to lane 0.
                            ptr_d  = '0;
                            lane_d = '0;
                            idl_d  = 1'b1;
                        end else if (nsr_c == IDLE_SYM) begin
                            idl_d = 1'b1;
                        end else begin
                            byte_out_d = nsr_c;
                            byte_stb_d = 1'b1;
                            lane_d     = ptr_q;
                            ptr_d      = ptr_q + LANE_W'(1);
                            idl_d      = 1'b0;
                        end
                    end
                end
                default: begin
                    state_d = S_SEARCH;
                end
            endcase
        end

        active_d = (state_d == S_ACTIVE);
    end

    assign bus.byte_out = byte_out_q;
    assign bus.byte_stb = byte_stb_q;
    assign bus.lane_sel = lane_q;
    assign bus.active   = active_q;
    assign bus.idl      = idl_q;
    assign bus.state    = state_q;

endmodule

// File: tb/tb_phy_rx_sync_ctrl.sv
// Purpose: self-checking bench for phy_rx_sync_ctrl. Symbol-level vectors
//          carry the expected status after each byte; expected data strobes
//          are queued when a data byte is sent and matched by a monitor
//          when the DUT strobes.
module tb_phy_rx_sync_ctrl;
    logic clk;
    logic rst;

    phy_rx_sync_ctrl_if bus ();

    phy_rx_sync_ctrl #(
        .COMMA      (8'hBC),
        .IDLE_SYM   (8'h7C),
        .LOCK_COUNT (4)
    ) dut (
        .clk_32f (clk),
        .rst     (rst),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] sym;
        logic       stb;
        logic [1:0] lane;
        logic       act;
        logic       idl;
        logic [1:0] st;
    } vec_t;

    typedef struct {
        logic [7:0] b;
        logic [1:0] l;
    } exp_t;

    vec_t vecs [0:22];
    exp_t sb_q [$];

    int checks     = 0;
    int errors     = 0;
    int cyc        = 0;
    int last_stb   = -1;
    int stb_count  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [7:0] sym, input logic stb, input logic [1:0] lane,
                                input logic act, input logic idl, input logic [1:0] st);
        vec_t v;
        v.sym = sym; v.stb = stb; v.lane = lane; v.act = act; v.idl = idl; v.st = st;
        return v;
    endfunction

    // Strobe monitor: scoreboard pop and minimum spacing
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (bus.byte_stb === 1'b1) begin
            chk("stb_expected", 32'(sb_q.size() > 0), 32'd1);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("byte_out", 32'(bus.byte_out), 32'(e.b));
                chk("lane_sel", 32'(bus.lane_sel), 32'(e.l));
            end
            if (last_stb >= 0) chk("stb_spacing", 32'((cyc - last_stb) >= 8), 32'd1);
            last_stb = cyc;
            stb_count++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        bus.data_in = b;
        tick();
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
    endtask

    task automatic run_vecs(input int lo, input int hi);
        exp_t e;
        for (int i = lo; i <= hi; i++) begin
            if (vecs[i].stb) begin
                e.b = vecs[i].sym;
                e.l = vecs[i].lane;
                sb_q.push_back(e);
            end
            send_byte(vecs[i].sym);
            chk($sformatf("v%0d_stb", i),    32'(bus.byte_stb), 32'(vecs[i].stb));
            chk($sformatf("v%0d_active", i), 32'(bus.active),   32'(vecs[i].act));
            chk($sformatf("v%0d_idl", i),    32'(bus.idl),      32'(vecs[i].idl));
            chk($sformatf("v%0d_state", i),  32'(bus.state),    32'(vecs[i].st));
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_byte_out"}, 32'(bus.byte_out), 32'h00);
        chk({tag, "_stb"},      32'(bus.byte_stb), 32'd0);
        chk({tag, "_lane"},     32'(bus.lane_sel), 32'd0);
        chk({tag, "_active"},   32'(bus.active),   32'd0);
        chk({tag, "_idl"},      32'(bus.idl),      32'd1);
        chk({tag, "_state"},    32'(bus.state),    32'd0);
    endtask

    initial begin
        // Lock, data lanes 0..3 wrap, then IDLE/COMMA handling while locked
        vecs[0]  = mk(8'hBC, 1'b0, 2'd0, 1'b0, 1'b1, 2'b01);
        vecs[1]  = mk(8'hBC, 1'b0, 2'd0, 1'b0, 1'b1, 2'b01);
        vecs[2]  = mk(8'hBC, 1'b0, 2'd0, 1'b0, 1'b1, 2'b01);
        vecs[3]  = mk(8'hBC, 1'b0, 2'd0, 1'b1, 1'b1, 2'b10);
        vecs[4]  = mk(8'h11, 1'b1, 2'd0, 1'b1, 1'b0, 2'b10);
        vecs[5]  = mk(8'h22, 1'b1, 2'd1, 1'b1, 1'b0, 2'b10);
        vecs[6]  = mk(8'h33, 1'b1, 2'd2, 1'b1, 1'b0, 2'b10);
        vecs[7]  = mk(8'h44, 1'b1, 2'd3, 1'b1, 1'b0, 2'b10);
        vecs[8]  = mk(8'h55, 1'b1, 2'd0, 1'b1, 1'b0, 2'b10);
        vecs[9]  = mk(8'hBC, 1'b0, 2'd0, 1'b1, 1'b1, 2'b10);
        vecs[10] = mk(8'h11, 1'b1, 2'd0, 1'b1, 1'b0, 2'b10);
        vecs[11] = mk(8'h7C, 1'b0, 2'd0, 1'b1, 1'b1, 2'b10);
        vecs[12] = mk(8'h22, 1'b1, 2'd1, 1'b1, 1'b0, 2'b10);
        vecs[13] = mk(8'hBC, 1'b0, 2'd0, 1'b1, 1'b1, 2'b10);
        vecs[14] = mk(8'h33, 1'b1, 2'd0, 1'b1, 1'b0, 2'b10);
        // Broken ALIGN run, then a fresh lock
        vecs[15] = mk(8'hBC, 1'b0, 2'd0, 1'b0, 1'b1, 2'b01);
        vecs[16] = mk(8'hBC, 1'b0, 2'd0, 1'b0, 1'b1, 2'b01);
        vecs[17] = mk(8'h5A, 1'b0, 2'd0, 1'b0, 1'b1, 2'b00);
        vecs[18] = mk(8'hBC, 1'b0, 2'd0, 1'b0, 1'b1, 2'b01);
        vecs[19] = mk(8'hBC, 1'b0, 2'd0, 1'b0, 1'b1, 2'b01);
        vecs[20] = mk(8'hBC, 1'b0, 2'd0, 1'b0, 1'b1, 2'b01);
        vecs[21] = mk(8'hBC, 1'b0, 2'd0, 1'b1, 1'b1, 2'b10);
        vecs[22] = mk(8'h66, 1'b1, 2'd0, 1'b1, 1'b0, 2'b10);

        // Reset held for 3 cycles, then idle zeros
        rst = 1'b1;
        bus.rx_en = 1'b1;
        bus.data_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_reset_vals($sformatf("rst%0d", i));
        end
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send_bit(1'b0);
            chk("idle_state", 32'(bus.state), 32'd0);
            chk("idle_idl",   32'(bus.idl),   32'd1);
        end

        // Garbage bits before the first COMMA
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        run_vecs(0, 14);

        // Drop rx_en for one cycle mid-byte
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        bus.rx_en = 1'b0;
        send_bit(1'b0);
        chk("rxen_state",    32'(bus.state),    32'd0);
        chk("rxen_active",   32'(bus.active),   32'd0);
        chk("rxen_idl",      32'(bus.idl),      32'd1);
        chk("rxen_byte_out", 32'(bus.byte_out), 32'h33);
        chk("rxen_lane",     32'(bus.lane_sel), 32'd0);
        chk("rxen_stb",      32'(bus.byte_stb), 32'd0);
        bus.rx_en = 1'b1;
        for (int i = 0; i < 8; i++) send_bit(1'b0);
        run_vecs(15, 22);

        // Reset for one cycle mid-byte while locked
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b1);
        rst = 1'b1;
        send_bit(1'b0);
        chk_reset_vals("midrst");
        rst = 1'b0;
        for (int i = 0; i < 12; i++) send_bit(1'b0);
        chk("post_rst_state",  32'(bus.state),  32'd0);
        chk("post_rst_active", 32'(bus.active), 32'd0);

        tick();
        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        chk("stb_count",  32'(stb_count),   32'd9);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
